piso_shift_tx: RTL

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 84 ++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts one WIDTH-bit word, sends it MSB first,
// holding each bit for DIV enabled clock cycles. shift_en pauses the bit timing.
module piso_shift_tx #(
   parameter int WIDTH = 4,
   parameter int DIV   = 50_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             bit_strobe,
   output logic             busy,
   output logic             done
);

   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BCW = $clog2(WIDTH);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BCW-1:0]   bit_cnt;
   logic [DCW-1:0]   div_cnt;
   logic             tick;

   assign load_ready = (state == IDLE);
   assign busy       = (state == SHIFT);
   assign tick       = shift_en && (div_cnt == DIV_LAST);

   // shreg holds the bits still waiting to be presented, MSB-aligned, so the
   // next bit is always shreg[WIDTH-1] and the current bit lives only in serial_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         serial_out <= 1'b0;
         bit_strobe <= 1'b0;
         done       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every branch reads pre-edge state.
         bit_strobe <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  shreg      <= load_data << 1;
                  bit_cnt    <= '0;
                  div_cnt    <= '0;
                  serial_out <= load_data[WIDTH-1];
                  bit_strobe <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     state      <= IDLE;
                     serial_out <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     shreg      <= shreg << 1;
                     serial_out <= shreg[WIDTH-1];
                     bit_cnt    <= bit_cnt + 1'b1;
                     bit_strobe <= 1'b1;
                  end
               end else if (shift_en) begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
